// File: rtl/leve1_csr_exec_if.sv
// Bundle of the issue, CSR-file and writeback ports of the CSR execution unit.
// master = execution unit, slave = surrounding pipeline / CSR file.
interface leve1_csr_exec_if #(
   parameter int XLEN = 64
);
   logic            REQ_VALID;
   logic            REQ_READY;
   logic [2:0]      REQ_FUNCT3;
   logic [11:0]     REQ_CSR;
   logic [4:0]      REQ_RS1_IDX;
   logic [XLEN-1:0] REQ_RS1_DATA;
   logic [4:0]      REQ_RD_IDX;
   logic [1:0]      PRIV;
   logic [11:0]     CSR_RA;
   logic [XLEN-1:0] CSR_RD;
   logic [1:0]      CSR_WCMD;
   logic [11:0]     CSR_WA;
   logic [XLEN-1:0] CSR_WD;
   logic            RESP_VALID;
   logic            RESP_READY;
   logic [4:0]      RESP_RD_IDX;
   logic [XLEN-1:0] RESP_RD_DATA;
   logic            RESP_WE;
   logic            RESP_ILLEGAL;
   logic            RETIRE;

   modport master (
      input  REQ_VALID, REQ_FUNCT3, REQ_CSR, REQ_RS1_IDX, REQ_RS1_DATA, REQ_RD_IDX, PRIV,
      output REQ_READY,
      output CSR_RA, CSR_WCMD, CSR_WA, CSR_WD,
      input  CSR_RD,
      output RESP_VALID, RESP_RD_IDX, RESP_RD_DATA, RESP_WE, RESP_ILLEGAL, RETIRE,
      input  RESP_READY
   );

   modport slave (
      output REQ_VALID, REQ_FUNCT3, REQ_CSR, REQ_RS1_IDX, REQ_RS1_DATA, REQ_RD_IDX, PRIV,
      input  REQ_READY,
      input  CSR_RA, CSR_WCMD, CSR_WA, CSR_WD,
      output CSR_RD,
      input  RESP_VALID, RESP_RD_IDX, RESP_RD_DATA, RESP_WE, RESP_ILLEGAL, RETIRE,
      output RESP_READY
   );
endinterface

// File: rtl/leve1_csr_exec.sv
// CSR-instruction execution unit: privilege/read-only checks, read, read-modify-write
// and old-value return for CSRRW/RS/RC and their immediate forms.
module leve1_csr_exec_chk (
   input logic       CLK,
   input logic       RSTn,
   input logic       req_ready,
   input logic       resp_valid,
   input logic [1:0] csr_wcmd,
   input logic       retire
);
   // Handshake invariants: one op in flight, writes only mid-op, retire only with a response.
   always @(posedge CLK) begin
      if (RSTn) begin
         assert (!(req_ready && resp_valid));
         assert ((csr_wcmd == 2'd0) || (!req_ready && !resp_valid));
         assert (!retire || resp_valid);
      end
   end
endmodule

module leve1_csr_exec #(
   parameter int         XLEN   = 64,
   parameter logic [1:0] PRIV_M = 2'd3
) (
   input logic             CLK,
   input logic             RSTn,
   leve1_csr_exec_if.master bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t          state_r;
   logic [1:0]      op_r;
   logic            use_imm_r;
   logic [4:0]      rs1_idx_r;
   logic [XLEN-1:0] rs1_data_r;
   logic            do_write_r;
   logic [4:0]      rd_idx_r;
   logic            req_ready_r;
   logic [11:0]     csr_ra_r;
   logic [11:0]     csr_wa_r;
   logic            resp_valid_r;
   logic [4:0]      resp_rd_idx_r;
   logic [XLEN-1:0] resp_rd_data_r;
   logic            resp_we_r;
   logic            resp_illegal_r;

   logic            do_write_s;
   logic            priv_ok_s;
   logic            illegal_s;
   logic [XLEN-1:0] src_s;
   logic [1:0]      wcmd_s;
   logic [XLEN-1:0] wd_s;
   logic            retire_s;

   // funct3[1:0]: 01 write, 10 set, 11 clear; the CSR file command uses the same code.
   function automatic logic [XLEN-1:0] rmw_value(input logic [1:0]      op,
                                                 input logic [XLEN-1:0] old_val,
                                                 input logic [XLEN-1:0] src);
      case (op)
         2'b01:   rmw_value = src;
         2'b10:   rmw_value = old_val | src;
         2'b11:   rmw_value = old_val & ~src;
         default: rmw_value = old_val;
      endcase
   endfunction

   // Legality of the op presented at the request port (evaluated only at accept).
   always_comb begin
      do_write_s = (bus.REQ_FUNCT3[1:0] == 2'b01) || (bus.REQ_RS1_IDX != 5'd0);
      priv_ok_s  = (bus.PRIV == PRIV_M) || (bus.REQ_CSR[9:8] <= bus.PRIV);
      illegal_s  = (bus.REQ_FUNCT3[1:0] == 2'b00) || !priv_ok_s ||
                   ((bus.REQ_CSR[11:10] == 2'b11) && do_write_s);
   end

   // Write port is driven only in the WRITE cycle, when CSR_RD carries the old value.
   always_comb begin
      src_s  = use_imm_r ? {{(XLEN-5){1'b0}}, rs1_idx_r} : rs1_data_r;
      wcmd_s = 2'd0;
      wd_s   = {XLEN{1'b0}};
      if ((state_r == ST_WRITE) && do_write_r) begin
         wcmd_s = op_r;
         wd_s   = rmw_value(op_r, bus.CSR_RD, src_s);
      end else begin
         wcmd_s = 2'd0;
         wd_s   = {XLEN{1'b0}};
      end
      retire_s = resp_valid_r && bus.RESP_READY && !resp_illegal_r;
   end

   // Op sequencer: IDLE -> READ -> WRITE -> RESP, illegal ops skip straight to RESP.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_r        <= ST_IDLE;
         op_r           <= 2'd0;
         use_imm_r      <= 1'b0;
         rs1_idx_r      <= 5'd0;
         rs1_data_r     <= {XLEN{1'b0}};
         do_write_r     <= 1'b0;
         rd_idx_r       <= 5'd0;
         req_ready_r    <= 1'b1;
         csr_ra_r       <= 12'd0;
         csr_wa_r       <= 12'd0;
         resp_valid_r   <= 1'b0;
         resp_rd_idx_r  <= 5'd0;
         resp_rd_data_r <= {XLEN{1'b0}};
         resp_we_r      <= 1'b0;
         resp_illegal_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.REQ_VALID) begin
                  op_r        <= bus.REQ_FUNCT3[1:0];
                  use_imm_r   <= bus.REQ_FUNCT3[2];
                  rs1_idx_r   <= bus.REQ_RS1_IDX;
                  rs1_data_r  <= bus.REQ_RS1_DATA;
                  do_write_r  <= do_write_s;
                  rd_idx_r    <= bus.REQ_RD_IDX;
                  req_ready_r <= 1'b0;
                  if (illegal_s) begin
                     resp_valid_r   <= 1'b1;
                     resp_illegal_r <= 1'b1;
                     resp_rd_idx_r  <= bus.REQ_RD_IDX;
                     resp_rd_data_r <= {XLEN{1'b0}};
                     resp_we_r      <= 1'b0;
                     state_r        <= ST_RESP;
                  end else begin
                     csr_ra_r <= bus.REQ_CSR;
                     csr_wa_r <= bus.REQ_CSR;
                     state_r  <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               state_r <= ST_WRITE;
            end
            ST_WRITE: begin
               resp_valid_r   <= 1'b1;
               resp_illegal_r <= 1'b0;
               resp_rd_idx_r  <= rd_idx_r;
               resp_rd_data_r <= bus.CSR_RD;
               resp_we_r      <= (rd_idx_r != 5'd0);
               state_r        <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.RESP_READY) begin
                  resp_valid_r   <= 1'b0;
                  resp_illegal_r <= 1'b0;
                  resp_rd_idx_r  <= 5'd0;
                  resp_rd_data_r <= {XLEN{1'b0}};
                  resp_we_r      <= 1'b0;
                  req_ready_r    <= 1'b1;
                  state_r        <= ST_IDLE;
               end
            end
            default: begin
               resp_valid_r <= 1'b0;
               req_ready_r  <= 1'b1;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.REQ_READY    = req_ready_r;
   assign bus.CSR_RA       = csr_ra_r;
   assign bus.CSR_WA       = csr_wa_r;
   assign bus.CSR_WCMD     = wcmd_s;
   assign bus.CSR_WD       = wd_s;
   assign bus.RESP_VALID   = resp_valid_r;
   assign bus.RESP_RD_IDX  = resp_rd_idx_r;
   assign bus.RESP_RD_DATA = resp_rd_data_r;
   assign bus.RESP_WE      = resp_we_r;
   assign bus.RESP_ILLEGAL = resp_illegal_r;
   assign bus.RETIRE       = retire_s;

   leve1_csr_exec_chk u_chk (
      .CLK        (CLK),
      .RSTn       (RSTn),
      .req_ready  (req_ready_r),
      .resp_valid (resp_valid_r),
      .csr_wcmd   (wcmd_s),
      .retire     (retire_s)
   );
endmodule

// File: tb/tb_leve1_csr_exec.sv
// Directed bench for leve1_csr_exec with a behavioural CSR file (registered read port).
module tb_leve1_csr_exec;
   localparam int XLEN = 64;

   logic CLK  = 1'b0;
   logic RSTn = 1'b1;
   always #5 CLK = ~CLK;

   leve1_csr_exec_if #(.XLEN(XLEN)) bus ();

   leve1_csr_exec #(.XLEN(XLEN), .PRIV_M(2'd3)) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus.master)
   );

   logic [63:0] csr_mem [0:4095];
   int          total = 0;
   int          bad   = 0;
   int          wcnt  = 0;
   int          rcnt  = 0;
   logic [1:0]  last_wcmd = 2'd0;
   logic [63:0] last_wd   = 64'd0;
   logic [11:0] last_wa   = 12'd0;

   // CSR file: registered read, write committed on any nonzero command; also counts retires.
   always @(posedge CLK) begin
      bus.CSR_RD <= csr_mem[bus.CSR_RA];
      if (bus.CSR_WCMD != 2'd0) begin
         csr_mem[bus.CSR_WA] = bus.CSR_WD;
         wcnt      = wcnt + 1;
         last_wcmd = bus.CSR_WCMD;
         last_wd   = bus.CSR_WD;
         last_wa   = bus.CSR_WA;
      end
      if (bus.RETIRE) rcnt = rcnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [11:0] csr,
                         input logic [4:0] rs1, input logic [63:0] d, input logic [4:0] rd,
                         input logic [1:0] pv, input int hold, input logic exp_ill,
                         input logic [63:0] exp_rd, input logic exp_we,
                         input logic [1:0] exp_wcmd, input logic [63:0] exp_wd);
      int lat;
      int rc0;
      logic [11:0] ra0;
      @(negedge CLK);
      chk({tag, ".req_ready"}, 64'(bus.REQ_READY), 64'd1);
      ra0 = bus.CSR_RA;
      wcnt = 0; last_wcmd = 2'd0; last_wd = 64'd0; last_wa = 12'd0;
      bus.REQ_VALID = 1'b1; bus.REQ_FUNCT3 = f3; bus.REQ_CSR = csr;
      bus.REQ_RS1_IDX = rs1; bus.REQ_RS1_DATA = d; bus.REQ_RD_IDX = rd; bus.PRIV = pv;
      @(posedge CLK);
      #1;
      bus.REQ_VALID = 1'b0;
      bus.PRIV = 2'd0;
      lat = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge CLK);
         if (bus.RESP_VALID) break;
         @(posedge CLK);
         lat = lat + 1;
      end
      chk({tag, ".resp_valid"}, 64'(bus.RESP_VALID), 64'd1);
      chk({tag, ".latency"}, 64'(lat), exp_ill ? 64'd0 : 64'd2);
      chk({tag, ".illegal"}, 64'(bus.RESP_ILLEGAL), 64'(exp_ill));
      chk({tag, ".rd_data"}, bus.RESP_RD_DATA, exp_rd);
      chk({tag, ".we"}, 64'(bus.RESP_WE), 64'(exp_we));
      chk({tag, ".rd_idx"}, 64'(bus.RESP_RD_IDX), 64'(rd));
      chk({tag, ".wcount"}, 64'(wcnt), (exp_wcmd != 2'd0) ? 64'd1 : 64'd0);
      chk({tag, ".wcmd"}, 64'(last_wcmd), 64'(exp_wcmd));
      chk({tag, ".wd"}, last_wd, exp_wd);
      chk({tag, ".wa"}, 64'(last_wa), (exp_wcmd != 2'd0) ? 64'(csr) : 64'd0);
      if (exp_ill) chk({tag, ".ra_untouched"}, 64'(bus.CSR_RA), 64'(ra0));
      else         chk({tag, ".ra"}, 64'(bus.CSR_RA), 64'(csr));
      chk({tag, ".busy"}, 64'(bus.REQ_READY), 64'd0);
      for (int i = 0; i < hold; i++) begin
         @(posedge CLK);
         @(negedge CLK);
         chk({tag, ".hold_valid"}, 64'(bus.RESP_VALID), 64'd1);
         chk({tag, ".hold_data"}, bus.RESP_RD_DATA, exp_rd);
         chk({tag, ".hold_busy"}, 64'(bus.REQ_READY), 64'd0);
         chk({tag, ".hold_retire"}, 64'(bus.RETIRE), 64'd0);
      end
      rc0 = rcnt;
      bus.RESP_READY = 1'b1;
      #1;
      chk({tag, ".retire"}, 64'(bus.RETIRE), exp_ill ? 64'd0 : 64'd1);
      @(posedge CLK);
      @(negedge CLK);
      bus.RESP_READY = 1'b0;
      chk({tag, ".retire_count"}, 64'(rcnt - rc0), exp_ill ? 64'd0 : 64'd1);
      chk({tag, ".done_valid"}, 64'(bus.RESP_VALID), 64'd0);
      chk({tag, ".done_ready"}, 64'(bus.REQ_READY), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      for (int a = 0; a < 4096; a++) csr_mem[a] = 64'd0;
      bus.REQ_VALID = 1'b0; bus.REQ_FUNCT3 = 3'd0; bus.REQ_CSR = 12'd0;
      bus.REQ_RS1_IDX = 5'd0; bus.REQ_RS1_DATA = 64'd0; bus.REQ_RD_IDX = 5'd0;
      bus.PRIV = 2'd3; bus.RESP_READY = 1'b0;
      #1 RSTn = 1'b0;
      #2;
      chk("rst.req_ready", 64'(bus.REQ_READY), 64'd1);
      chk("rst.ra", 64'(bus.CSR_RA), 64'd0);
      chk("rst.wa", 64'(bus.CSR_WA), 64'd0);
      chk("rst.wcmd", 64'(bus.CSR_WCMD), 64'd0);
      chk("rst.wd", bus.CSR_WD, 64'd0);
      chk("rst.resp_valid", 64'(bus.RESP_VALID), 64'd0);
      chk("rst.resp_data", bus.RESP_RD_DATA, 64'd0);
      chk("rst.illegal", 64'(bus.RESP_ILLEGAL), 64'd0);
      chk("rst.retire", 64'(bus.RETIRE), 64'd0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RSTn = 1'b1;

      csr_mem[12'h305] = 64'h100;
      run_op("rw_mtvec", 3'b001, 12'h305, 5'd1, 64'h8000_0000, 5'd5, 2'd3, 0,
             1'b0, 64'h100, 1'b1, 2'd1, 64'h8000_0000);
      chk("rw_mtvec.mem", csr_mem[12'h305], 64'h8000_0000);

      csr_mem[12'h300] = 64'h0A00;
      run_op("rs_x0", 3'b010, 12'h300, 5'd0, 64'hFFFF, 5'd6, 2'd3, 0,
             1'b0, 64'h0A00, 1'b1, 2'd0, 64'd0);

      csr_mem[12'h300] = 64'h0A08;
      run_op("rci_bp", 3'b111, 12'h300, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 2'd3, 5,
             1'b0, 64'h0A08, 1'b1, 2'd3, 64'h0A00);
      chk("rci_bp.mem", csr_mem[12'h300], 64'h0A00);

      run_op("rw_upriv", 3'b001, 12'h300, 5'd1, 64'h1234, 5'd3, 2'd1, 0,
             1'b1, 64'd0, 1'b0, 2'd0, 64'd0);
      run_op("rw_cycle", 3'b001, 12'hC00, 5'd2, 64'h55, 5'd4, 2'd3, 0,
             1'b1, 64'd0, 1'b0, 2'd0, 64'd0);

      csr_mem[12'hC00] = 64'h1234_5678_9ABC;
      run_op("rs_cycle_u", 3'b010, 12'hC00, 5'd0, 64'd0, 5'd8, 2'd0, 0,
             1'b0, 64'h1234_5678_9ABC, 1'b1, 2'd0, 64'd0);

      run_op("f3_000", 3'b000, 12'h300, 5'd1, 64'd1, 5'd2, 2'd3, 0,
             1'b1, 64'd0, 1'b0, 2'd0, 64'd0);
      run_op("f3_100", 3'b100, 12'h300, 5'd1, 64'd1, 5'd2, 2'd3, 0,
             1'b1, 64'd0, 1'b0, 2'd0, 64'd0);

      csr_mem[12'h340] = 64'h30;
      run_op("rw_x0", 3'b001, 12'h340, 5'd1, 64'h77, 5'd0, 2'd3, 0,
             1'b0, 64'h30, 1'b0, 2'd1, 64'h77);

      csr_mem[12'h341] = 64'hF0;
      run_op("rs_reg", 3'b010, 12'h341, 5'd3, 64'h0F, 5'd9, 2'd3, 1,
             1'b0, 64'hF0, 1'b1, 2'd2, 64'hFF);

      // Abort an op in its READ cycle with an asynchronous reset.
      @(negedge CLK);
      wcnt = 0;
      bus.REQ_VALID = 1'b1; bus.REQ_FUNCT3 = 3'b001; bus.REQ_CSR = 12'h305;
      bus.REQ_RS1_IDX = 5'd1; bus.REQ_RS1_DATA = 64'hDEAD; bus.REQ_RD_IDX = 5'd5; bus.PRIV = 2'd3;
      @(posedge CLK);
      #1 bus.REQ_VALID = 1'b0;
      #2 RSTn = 1'b0;
      #1;
      chk("arst.req_ready", 64'(bus.REQ_READY), 64'd1);
      chk("arst.ra", 64'(bus.CSR_RA), 64'd0);
      chk("arst.wa", 64'(bus.CSR_WA), 64'd0);
      chk("arst.wcmd", 64'(bus.CSR_WCMD), 64'd0);
      chk("arst.resp_valid", 64'(bus.RESP_VALID), 64'd0);
      chk("arst.retire", 64'(bus.RETIRE), 64'd0);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("arst.no_write", 64'(wcnt), 64'd0);
      chk("arst.mem", csr_mem[12'h305], 64'h8000_0000);
      RSTn = 1'b1;

      run_op("after_rst", 3'b110, 12'h305, 5'd3, 64'd0, 5'd1, 2'd3, 0,
             1'b0, 64'h8000_0000, 1'b1, 2'd2, 64'h8000_0003);
      chk("after_rst.mem", csr_mem[12'h305], 64'h8000_0003);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/leve1_csr_exec.md
Name: leve1_csr_exec

Overview:
- CSR-instruction execution unit; the initiator side of the CSR file's read/write port.
- Accepts decoded CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI ops from issue and performs privilege and read-only checks.
- Issues a read, computes the read-modify-write value and issues the write.
- Returns the old CSR value for rd writeback and pulses RETIRE on completion.

Parameters:
XLEN, 64, data width; matches the CSR file.
PRIV_M, 2'd3, machine-mode encoding on PRIV.

Ports:
CLK  in  1  clock
RSTn  in  1  asynchronous, active-low reset
REQ_VALID  in  1  op valid
REQ_READY  out  1  unit can accept
REQ_FUNCT3  in  3  instr[14:12]
REQ_CSR  in  12  CSR address
REQ_RS1_IDX  in  5  rs1 index / uimm
REQ_RS1_DATA  in  XLEN  rs1 value
REQ_RD_IDX  in  5  destination register
PRIV  in  2  current privilege mode (0 U, 1 S, 3 M)
CSR_RA  out  12  read address to CSR file
CSR_RD  in  XLEN  read data; registered in the CSR file, valid the cycle after CSR_RA
CSR_WCMD  out  2  0 none, 1 write, 2 set, 3 clear; nonzero means commit CSR_WD
CSR_WA  out  12  write address
CSR_WD  out  XLEN  final value to write, already combined
RESP_VALID  out  1  result valid
RESP_READY  in  1  writeback accepts
RESP_RD_IDX  out  5  destination register
RESP_RD_DATA  out  XLEN  old CSR value
RESP_WE  out  1  rd write enable; 0 when rd==x0 or illegal
RESP_ILLEGAL  out  1  illegal-instruction exception
RETIRE  out  1  one-cycle pulse per legal completed op

Behaviour:
- Reset (async): state IDLE; REQ_READY=1 is the only nonzero output. CSR_RA, CSR_WA, CSR_WD, CSR_WCMD, RESP_*, RETIRE = 0. An in-flight op is dropped without a write.
- FSM states: IDLE, READ, WRITE, RESP.

IDLE:
- REQ_READY=1.
- On REQ_VALID, latch all REQ fields and PRIV.
- If illegal, go to RESP with RESP_ILLEGAL=1; otherwise go to READ.

READ:
- CSR_RA = latched address, held registered from the accept edge.
- Always go to WRITE.

WRITE:
- Sample CSR_RD into old.
- src = REQ_RS1_DATA for funct3[2]=0; zero-extended uimm for funct3[2]=1.
- new value by op:
  - RW: src, WCMD=1.
  - RS: old | src, WCMD=2.
  - RC: old & ~src, WCMD=3.
- do_write = RW variants always; RS/RC only when REQ_RS1_IDX != 0.
- CSR_WCMD is nonzero for exactly this one cycle when do_write. CSR_WA = address, CSR_WD = new value.
- Go to RESP.

RESP:
- RESP_VALID=1; fields held stable until RESP_READY.
- On RESP_VALID & RESP_READY:
  - RETIRE pulses that cycle if not illegal.
  - Go to IDLE.
- REQ_READY=0 in all states except IDLE. No back-to-back overlap.

Illegal conditions:
- funct3 == 000 or 100.
- REQ_CSR[9:8] > PRIV.
- REQ_CSR[11:10]==2'b11 and do_write.
- Illegal ops issue neither a read nor a write (CSR_WCMD stays 0). RESP_RD_DATA=0, RESP_WE=0.

Timing and data rules:
- Latency for legal ops: accept at edge t0, WCMD high in cycle t1..t2, RESP_VALID from t2.
- CSRRW with rd=x0 still reads and writes; RESP_WE=0.
- Widths: uimm zero-extended to XLEN. No arithmetic overflow is possible.
- PRIV is sampled only at accept; changes mid-op are ignored.

Test Plan:
- CSRRW 0x305 (mtvec), rs1=0x8000_0000, rd=x5, PRIV=3, mtvec=0x100 -> one WCMD=1 pulse with WD=0x8000_0000. RESP_RD_DATA=0x100, RESP_WE=1, RETIRE=1. RESP_VALID 2 cycles after accept.
- CSRRS 0x300, rs1=x0, rd=x6, mstatus=0x0A00 -> CSR_WCMD never asserted. RESP_RD_DATA=0x0A00, RETIRE=1.
- CSRRCI 0x300, uimm=0x08, mstatus=0x0A08 -> WCMD=3, WD=0x0A00. Old value 0x0A08 returned.
- CSRRW 0x300 at PRIV=1 -> RESP_ILLEGAL=1, no read or write, RETIRE=0. CSRRW 0xC00 (cycle) at PRIV=3 -> illegal. CSRRS 0xC00 with rs1=x0 -> legal, returns the counter.
- RESP_READY held low 5 cycles after RESP_VALID -> outputs stable, REQ_READY=0, exactly one RETIRE when finally accepted.
- RSTn asserted during READ -> all outputs 0 asynchronously, no CSR write. After release, a new op completes normally.
